// File: rtl/uart_pkg.sv
// uart_pkg: shared enums, oversampling constants and parity helpers for uart_ext
package uart_pkg;
  localparam int OVS = 16;
  localparam int START_MID = 7;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_mode_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  function automatic logic par_en(input logic [1:0] m);
    return m == PAR_EVEN || m == PAR_ODD;
  endfunction
  function automatic logic par_bit(input logic [1:0] m, input logic x);
    return (m == PAR_ODD) ? ~x : x;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO, head reads as zero while empty
module uart_fifo #(
  parameter int W = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  logic [W-1:0] r_mem [2**AW];
  logic [AW:0]  r_wp, r_rp;
  logic         w_we, w_re;
  assign w_we = i_wr & (~o_full | i_rd);
  assign w_re = i_rd & ~o_empty;
  assign o_empty = r_wp == r_rp;
  assign o_full = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
  assign o_data = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_we) r_wp <= r_wp + 1'b1;
      if (w_re) r_rp <= r_rp + 1'b1;
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/uart_ext.sv
// uart_ext: 16x-oversampled UART with runtime parity, error flags, overrun and FIFOs (optional UART_LOOPBACK_EN)
module uart_ext import uart_pkg::*; #(
  parameter int DBITS = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 4,
  parameter int DIVW = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIVW-1:0]  div,
  input  logic [1:0]       parity_mode,
  input  logic             rx,
  input  logic             rd_uart,
  output logic [DBITS-1:0] r_data,
  output logic             r_perr,
  output logic             r_ferr,
  output logic             rx_empty,
  output logic             rx_overrun,
  input  logic             clr_overrun,
  input  logic [DBITS-1:0] w_data,
  input  logic             wr_uart,
  output logic             tx_full,
  output logic             tx_busy,
`ifdef UART_LOOPBACK_EN
  input  logic             loopback,
`endif
  output logic             tx
);
  localparam int SW = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);
  localparam int NW = $clog2(DBITS);
  logic [DIVW-1:0]  r_bcnt;
  logic             w_tick, w_rx_in, w_rxs, w_rx_push, w_rx_full, r_ovr;
  logic [1:0]       r_sync;
  rx_state_t        r_rst, w_rst_n;
  logic [SW-1:0]    r_rs, w_rs_n;
  logic [NW-1:0]    r_rn, w_rn_n;
  logic [DBITS-1:0] r_rb, w_rb_n;
  logic [1:0]       r_rpm, w_rpm_n;
  logic             r_rperr, w_rperr_n;
  logic [DBITS+1:0] w_rx_word, w_rx_head;
  tx_state_t        r_tst, w_tst_n;
  logic [SW-1:0]    r_ts, w_ts_n;
  logic [NW-1:0]    r_tn, w_tn_n;
  logic [DBITS-1:0] r_tb, w_tb_n, w_tx_head;
  logic [1:0]       r_tpm, w_tpm_n;
  logic             r_tp, w_tp_n, r_tx, w_tx_n, w_tx_pop, w_tx_empty, w_tbit, w_tstop;
`ifdef UART_LOOPBACK_EN
  assign w_rx_in = loopback ? r_tx : rx;
  assign tx = loopback ? 1'b1 : r_tx;
`else
  assign w_rx_in = rx;
  assign tx = r_tx;
`endif
  assign w_tick = r_bcnt == div;
  assign w_rx_word = {~w_rxs, r_rperr, r_rb};
  assign {r_ferr, r_perr, r_data} = w_rx_head;
  assign rx_overrun = r_ovr;
  assign tx_busy = r_tst != TX_IDLE;
  assign w_tbit = w_tick & (r_ts == SW'(OVS - 1));
  assign w_tstop = w_tick & (r_ts == SW'(SB_TICK - 1));
  assign w_tx_pop = ~w_tx_empty & ((r_tst == TX_IDLE) | ((r_tst == TX_STOP) & w_tstop));
  // baud divider, synchronizer and overrun flag (set beats clear)
  always_ff @(posedge clk) begin
    r_bcnt <= (reset | w_tick) ? '0 : r_bcnt + 1'b1;
    r_sync <= reset ? 2'b11 : {r_sync[0], w_rx_in};
    r_ovr <= reset ? 1'b0 : (w_rx_push & w_rx_full & ~rd_uart) ? 1'b1 : clr_overrun ? 1'b0 : r_ovr;
  end
  assign w_rxs = r_sync[1];
  // receiver and transmitter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rst <= RX_IDLE;
      r_rs <= '0;
      r_rn <= '0;
      r_rb <= '0;
      r_rpm <= '0;
      r_rperr <= 1'b0;
      r_tst <= TX_IDLE;
      r_ts <= '0;
      r_tn <= '0;
      r_tb <= '0;
      r_tpm <= '0;
      r_tp <= 1'b0;
      r_tx <= 1'b1;
    end else begin
      r_rst <= w_rst_n;
      r_rs <= w_rs_n;
      r_rn <= w_rn_n;
      r_rb <= w_rb_n;
      r_rpm <= w_rpm_n;
      r_rperr <= w_rperr_n;
      r_tst <= w_tst_n;
      r_ts <= w_ts_n;
      r_tn <= w_tn_n;
      r_tb <= w_tb_n;
      r_tpm <= w_tpm_n;
      r_tp <= w_tp_n;
      r_tx <= w_tx_n;
    end
  end
  // receiver: mid-bit sampling, start glitch rejection, error capture
  always_comb begin
    w_rst_n = r_rst;
    w_rs_n = w_tick ? r_rs + 1'b1 : r_rs;
    w_rn_n = r_rn;
    w_rb_n = r_rb;
    w_rpm_n = r_rpm;
    w_rperr_n = r_rperr;
    w_rx_push = 1'b0;
    case (r_rst)
      RX_IDLE: if (!w_rxs) begin
        w_rst_n = RX_START;
        w_rs_n = '0;
        w_rpm_n = parity_mode;
        w_rperr_n = 1'b0;
      end
      RX_START: if (w_tick && r_rs == SW'(START_MID)) begin
        w_rst_n = w_rxs ? RX_IDLE : RX_DATA;
        w_rs_n = '0;
        w_rn_n = '0;
      end
      RX_DATA: if (w_tick && r_rs == SW'(OVS - 1)) begin
        w_rs_n = '0;
        w_rb_n = {w_rxs, r_rb[DBITS-1:1]};
        w_rn_n = r_rn + 1'b1;
        if (r_rn == NW'(DBITS - 1)) w_rst_n = par_en(r_rpm) ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (w_tick && r_rs == SW'(OVS - 1)) begin
        w_rst_n = RX_STOP;
        w_rs_n = '0;
        w_rperr_n = w_rxs ^ par_bit(r_rpm, ^r_rb);
      end
      RX_STOP: if (w_tick && r_rs == SW'(SB_TICK - 1)) begin
        w_rst_n = RX_IDLE;
        w_rx_push = 1'b1;
      end
      default: w_rst_n = RX_IDLE;
    endcase
  end
  // transmitter: registered line, reloads straight from STOP for gapless bursts
  always_comb begin
    w_tst_n = r_tst;
    w_ts_n = w_tick ? r_ts + 1'b1 : r_ts;
    w_tn_n = r_tn;
    w_tb_n = r_tb;
    w_tpm_n = r_tpm;
    w_tp_n = r_tp;
    w_tx_n = r_tx;
    case (r_tst)
      TX_IDLE: w_tx_n = 1'b1;
      TX_START: if (w_tbit) begin
        w_tst_n = TX_DATA;
        w_ts_n = '0;
        w_tn_n = '0;
        w_tx_n = r_tb[0];
      end
      TX_DATA: if (w_tbit) begin
        w_ts_n = '0;
        w_tb_n = r_tb >> 1;
        w_tn_n = r_tn + 1'b1;
        w_tx_n = r_tb[1];
        if (r_tn == NW'(DBITS - 1)) begin
          w_tst_n = par_en(r_tpm) ? TX_PARITY : TX_STOP;
          w_tx_n = par_en(r_tpm) ? r_tp : 1'b1;
        end
      end
      TX_PARITY: if (w_tbit) begin
        w_tst_n = TX_STOP;
        w_ts_n = '0;
        w_tx_n = 1'b1;
      end
      TX_STOP: if (w_tstop) begin
        w_tst_n = TX_IDLE;
        w_tx_n = 1'b1;
      end
      default: w_tst_n = TX_IDLE;
    endcase
    if (w_tx_pop) begin
      w_tst_n = TX_START;
      w_ts_n = '0;
      w_tb_n = w_tx_head;
      w_tpm_n = parity_mode;
      w_tp_n = par_bit(parity_mode, ^w_tx_head);
      w_tx_n = 1'b0;
    end
  end
  uart_fifo #(.W(DBITS + 2), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .i_wr(w_rx_push), .i_rd(rd_uart), .i_data(w_rx_word),
    .o_data(w_rx_head), .o_empty(rx_empty), .o_full(w_rx_full)
  );
  uart_fifo #(.W(DBITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .i_wr(wr_uart), .i_rd(w_tx_pop), .i_data(w_data),
    .o_data(w_tx_head), .o_empty(w_tx_empty), .o_full(tx_full)
  );
endmodule

// File: tb/tb_uart_ext.sv
// tb_uart_ext: directed and randomized checks of uart_ext against a frame-level reference model
module tb_uart_ext;
  logic clk = 0, reset = 1;
  logic [10:0] div = 11'd3;
  logic [1:0] parity_mode = 2'd0;
  logic rx, rx_drv = 1, lb = 0;
  logic rd_uart = 0, clr_overrun = 0, wr_uart = 0;
  logic [7:0] w_data = 0, r_data;
  logic r_perr, r_ferr, rx_empty, rx_overrun, tx_full, tx_busy, tx;
  int checks = 0, errors = 0;
  logic [9:0] rxq[$];
  logic exp_ovr = 0;
  logic [7:0] bd [16];
  logic [7:0] x;
  int cnt, lows;

  assign rx = lb ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_ext dut (
    .clk(clk), .reset(reset), .div(div), .parity_mode(parity_mode), .rx(rx), .rd_uart(rd_uart),
    .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr), .rx_empty(rx_empty), .rx_overrun(rx_overrun),
    .clr_overrun(clr_overrun), .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full), .tx_busy(tx_busy),
`ifdef UART_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .tx(tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pbit(input logic [7:0] d, input logic [1:0] m);
    return (($countones(d) % 2) == 1) ^ (m == 2'd2);
  endfunction

  function automatic logic pen(input logic [1:0] m);
    return m == 2'd1 || m == 2'd2;
  endfunction

  task automatic tx_frame(input logic [7:0] d, input logic [1:0] m, input int skip);
    repeat (32 - skip) @(negedge clk);
    check("tx_start", tx, 0);
    parity_mode = ~m;
    for (int i = 0; i < 8; i++) begin
      repeat (64) @(negedge clk);
      check("tx_bit", tx, d[i]);
    end
    if (pen(m)) begin
      repeat (64) @(negedge clk);
      check("tx_par", tx, pbit(d, m));
    end
    repeat (64) @(negedge clk);
    check("tx_stop", tx, 1);
  endtask

  task automatic tx_send(input logic [7:0] d, input logic [1:0] m);
    parity_mode = m;
    w_data = d;
    wr_uart = 1;
    @(negedge clk);
    wr_uart = 0;
    check("lat_n1", tx, 1);
    @(negedge clk);
    check("lat_n2", tx, 0);
    check("busy_on", tx_busy, 1);
    tx_frame(d, m, 0);
    repeat (40) @(negedge clk);
    check("busy_off", tx_busy, 0);
  endtask

  task automatic wait_fall(output int c);
    c = 0;
    while (tx !== 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("fall_timeout", c < 2000, 1);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic [1:0] m, input logic bp, input logic bs);
    parity_mode = m;
    rx_drv = 0;
    repeat (64) @(negedge clk);
    parity_mode = ~m;
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (64) @(negedge clk);
    end
    if (pen(m)) begin
      rx_drv = pbit(d, m) ^ bp;
      repeat (64) @(negedge clk);
    end
    rx_drv = ~bs;
    repeat (bs ? 48 : 64) @(negedge clk);
    rx_drv = 1;
    repeat (bs ? 128 : 16) @(negedge clk);
    if (rxq.size() < 16) rxq.push_back({bs, pen(m) & bp, d});
    else exp_ovr = 1;
  endtask

  task automatic rx_read(input string tag);
    logic [9:0] e;
    check({tag, "_nonempty"}, rx_empty, 0);
    e = 10'h3ff;
    if (rxq.size() > 0) e = rxq.pop_front();
    check(tag, {r_ferr, r_perr, r_data}, e);
    rd_uart = 1;
    @(negedge clk);
    rd_uart = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_empty", rx_empty, 1);
    check("rst_full", tx_full, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_rword", {r_ferr, r_perr, r_data}, 0);
    reset = 0;
    repeat (5) @(negedge clk);

    tx_send(8'hA5, 2'd0);
    tx_send(8'h07, 2'd1);
    tx_send(8'h07, 2'd2);
    tx_send(8'($urandom), 2'd3);
    for (int k = 0; k < 2; k++) tx_send(8'($urandom), 2'($urandom_range(0, 3)));

    lb = 1;
    repeat (5) @(negedge clk);
    tx_send(8'hA5, 2'd0);
    rxq.push_back({2'b00, 8'hA5});
    rx_read("loop_a5");
    x = 8'($urandom);
    tx_send(x, 2'd1);
    rxq.push_back({2'b00, x});
    rx_read("loop_even");
    lb = 0;
    repeat (5) @(negedge clk);

    rx_send(8'h3C, 2'd0, 0, 1);
    rx_read("rx_ferr");
    rx_drv = 0;
    repeat (4) @(negedge clk);
    rx_drv = 1;
    repeat (200) @(negedge clk);
    check("glitch", rx_empty, 1);
    rx_send(8'h07, 2'd1, 1, 0);
    rx_read("rx_perr");
    for (int k = 0; k < 6; k++) begin
      rx_send(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rx_read("rx_rand");
    end

    parity_mode = 2'd0;
    x = 8'($urandom);
    w_data = x;
    wr_uart = 1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bd[i] = 8'($urandom);
      w_data = bd[i];
      @(negedge clk);
      if (i == 14) check("full_at_15", tx_full, 0);
    end
    check("full_at_16", tx_full, 1);
    w_data = 8'($urandom);
    @(negedge clk);
    check("full_drop", tx_full, 1);
    wr_uart = 0;
    tx_frame(x, 2'd0, 16);
    for (int i = 0; i < 16; i++) begin
      wait_fall(cnt);
      if (i == 0) check("gap_first", cnt >= 29 && cnt <= 32, 1);
      else check("gap", cnt, 32);
      tx_frame(bd[i], 2'd0, 0);
    end
    lows = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_extra_frame", lows, 0);
    check("burst_idle", tx_busy, 0);
    check("burst_notfull", tx_full, 0);

    for (int k = 0; k < 17; k++) begin
      rx_send(8'($urandom), 2'($urandom_range(0, 3)), 0, 0);
      if (k == 15) check("ovr_at_16", rx_overrun, 0);
    end
    check("ovr_set", rx_overrun, exp_ovr);
    for (int k = 0; k < 16; k++) rx_read("ovr_word");
    check("ovr_drained", rx_empty, 1);
    check("ovr_sticky", rx_overrun, exp_ovr);
    clr_overrun = 1;
    @(negedge clk);
    clr_overrun = 0;
    exp_ovr = 0;
    check("ovr_clr", rx_overrun, exp_ovr);

    rx_send(8'h5A, 2'd0, 0, 0);
    parity_mode = 2'd0;
    w_data = 8'h00;
    wr_uart = 1;
    repeat (17) @(negedge clk);
    wr_uart = 0;
    repeat (150) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_full", tx_full, 1);
    check("pre_rst_empty", rx_empty, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    rxq.delete();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_full", tx_full, 0);
    check("mid_rst_empty", rx_empty, 1);
    lows = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
